// File: rtl/cic_iq_decimator.sv
// Cascaded-integrator-comb decimator for a complex I/Q stream, R = 2**RL.
// Each decimated complex sample leaves as two adjacent one-cycle strobes:
// I first (out_q_nI=0), then Q (out_q_nI=1).
//
// Ports:
//   clk        clock, rising edge
//   reset_n    asynchronous active-low reset
//   in_valid   input I/Q pair valid (at most one per clk)
//   in_i/in_q  input samples, ISZ-bit two's complement
//   phase_clr  synchronous restart of the decimation phase counter
//   out_valid  output word strobe
//   out_q_nI   0: out carries I, 1: out carries Q
//   out        OSZ-bit rounded, saturated output word
module cic_iq_decimator #(
    parameter int unsigned ISZ = 12,
    parameter int unsigned OSZ = 16,
    parameter int unsigned N   = 3,
    parameter int unsigned RL  = 3
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           in_valid,
    input  logic [ISZ-1:0] in_i,
    input  logic [ISZ-1:0] in_q,
    input  logic           phase_clr,
    output logic           out_valid,
    output logic           out_q_nI,
    output logic [OSZ-1:0] out
);

    localparam int unsigned GROW = N * RL;
    localparam int unsigned W    = ISZ + GROW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_OUT_I,
        S_OUT_Q
    } state_t;

    logic [RL-1:0]  phase;
    logic           tick_c;
    // v[0] set on the tick edge; v[k] enables comb stage k; v[N+1] launches the I strobe
    logic [N+1:0]   v;

    logic [W-1:0]   integ_i [N];
    logic [W-1:0]   integ_q [N];
    logic [W-1:0]   comb_i  [N+1];
    logic [W-1:0]   comb_q  [N+1];
    logic [W-1:0]   dly_i   [N];
    logic [W-1:0]   dly_q   [N];

    logic [OSZ-1:0] sc_i_c;
    logic [OSZ-1:0] sc_q_c;
    logic [OSZ-1:0] q_hold;

    state_t         state_q;
    state_t         state_d;
    logic           out_valid_d;
    logic           out_q_nI_d;
    logic [OSZ-1:0] out_d;
    logic [OSZ-1:0] q_hold_d;

    // A tick is the input accepted with phase == R-1, unless phase_clr suppresses it
    assign tick_c = in_valid && !phase_clr && (&phase);

    // Phase counter and tick pipeline
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase <= '0;
            v     <= '0;
        end else begin
            if (phase_clr) begin
                phase <= '0;
            end else if (in_valid) begin
                phase <= phase + RL'(1);
            end
            v <= {v[N:0], tick_c};
        end
    end

    // Integrators: wrap modulo 2**W by design, each stage fed by the previous stage's register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < int'(N); k++) begin
                integ_i[k] <= '0;
                integ_q[k] <= '0;
            end
        end else if (in_valid) begin
            integ_i[0] <= integ_i[0] + W'($signed(in_i));
            integ_q[0] <= integ_q[0] + W'($signed(in_q));
            for (int k = 1; k < int'(N); k++) begin
                integ_i[k] <= integ_i[k] + integ_i[k-1];
                integ_q[k] <= integ_q[k] + integ_q[k-1];
            end
        end
    end

    // Comb pipeline: snapshot at tick+1, stage k at tick+1+k, differential delay of one
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k <= int'(N); k++) begin
                comb_i[k] <= '0;
                comb_q[k] <= '0;
            end
            for (int k = 0; k < int'(N); k++) begin
                dly_i[k] <= '0;
                dly_q[k] <= '0;
            end
        end else begin
            if (v[0]) begin
                comb_i[0] <= integ_i[N-1];
                comb_q[0] <= integ_q[N-1];
            end
            for (int k = 1; k <= int'(N); k++) begin
                if (v[k]) begin
                    comb_i[k]  <= comb_i[k-1] - dly_i[k-1];
                    comb_q[k]  <= comb_q[k-1] - dly_q[k-1];
                    dly_i[k-1] <= comb_i[k-1];
                    dly_q[k-1] <= comb_q[k-1];
                end
            end
        end
    end

    // Output scaling: round-half-up shift down with saturation, or plain left shift when narrow
    if (W > OSZ) begin : g_shr
        localparam int unsigned SH = W - OSZ;
        localparam int unsigned WX = W + 1;
        localparam logic signed [WX-1:0] SMAX = WX'((2 ** (OSZ - 1)) - 1);
        localparam logic signed [WX-1:0] SMIN = WX'(-(2 ** (OSZ - 1)));

        function automatic logic [OSZ-1:0] scale(input logic [W-1:0] c);
            logic signed [WX-1:0] sum;
            logic signed [WX-1:0] shr;
            sum = $signed({c[W-1], c}) + $signed(WX'(1) << (SH - 1));
            shr = sum >>> SH;
            if (shr > SMAX) begin
                scale = OSZ'(SMAX);
            end else if (shr < SMIN) begin
                scale = OSZ'(SMIN);
            end else begin
                scale = OSZ'(shr);
            end
        endfunction

        assign sc_i_c = scale(comb_i[N]);
        assign sc_q_c = scale(comb_q[N]);
    end else begin : g_shl
        assign sc_i_c = OSZ'($signed(comb_i[N])) << (OSZ - W);
        assign sc_q_c = OSZ'($signed(comb_q[N])) << (OSZ - W);
    end

    // Serializer state register and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            out_valid <= 1'b0;
            out_q_nI  <= 1'b0;
            out       <= '0;
            q_hold    <= '0;
        end else begin
            state_q   <= state_d;
            out_valid <= out_valid_d;
            out_q_nI  <= out_q_nI_d;
            out       <= out_d;
            q_hold    <= q_hold_d;
        end
    end

    // Serializer next state: Q is captured with I so a following tick cannot disturb it
    always_comb begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        out_q_nI_d  = out_q_nI;
        out_d       = out;
        q_hold_d    = q_hold;
        if (v[N+1]) begin
            state_d     = S_OUT_I;
            out_valid_d = 1'b1;
            out_q_nI_d  = 1'b0;
            out_d       = sc_i_c;
            q_hold_d    = sc_q_c;
        end else if (state_q == S_OUT_I) begin
            state_d     = S_OUT_Q;
            out_valid_d = 1'b1;
            out_q_nI_d  = 1'b1;
            out_d       = q_hold;
        end
    end

endmodule
